// File: rtl/counter_multi_ch.sv
// Multi-channel down-counter/timer: per-channel one-shot, auto-reload and square-wave modes,
// sticky done flags and a maskable registered interrupt. Tick sources are edge-detected in clk.
module counter_multi_ch #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 32,
    parameter int unsigned CHW = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NCH-1:0]   tick_in,
    input  logic             counter_we,
    input  logic             ctrl_sel,
    input  logic [CHW-1:0]   counter_ch,
    input  logic [CW-1:0]    counter_val,
    input  logic [CHW-1:0]   rd_ch,
    output logic [CW-1:0]    counter_out,
    output logic [NCH-1:0]   ch_out,
    output logic [NCH-1:0]   done,
    output logic             irq
);

    localparam logic [1:0]    MODE_OFF  = 2'b00;
    localparam logic [1:0]    MODE_ONE  = 2'b01;
    localparam logic [1:0]    MODE_AUTO = 2'b10;
    localparam logic [1:0]    MODE_SQR  = 2'b11;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0]  count_q  [NCH];
    logic [CW-1:0]  count_d  [NCH];
    logic [CW-1:0]  reload_q [NCH];
    logic [CW-1:0]  reload_d [NCH];
    logic [1:0]     mode_q   [NCH];
    logic [1:0]     mode_d   [NCH];
    logic [NCH-1:0] irq_en_q;
    logic [NCH-1:0] irq_en_d;
    logic [NCH-1:0] run_q;
    logic [NCH-1:0] run_d;
    logic [NCH-1:0] done_d;
    logic [NCH-1:0] ch_out_d;
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] tick_evt;
    logic [NCH-1:0] wr_hit;
    logic           irq_d;

    // Next-state for every channel; a write to a channel pre-empts its tick in the same cycle.
    always_comb begin
        tick_evt = tick_in & ~tick_q;
        wr_hit   = '0;
        run_d    = run_q;
        done_d   = done;
        ch_out_d = ch_out;
        irq_en_d = irq_en_q;
        irq_d    = |(done & irq_en_q);
        for (int i = 0; i < int'(NCH); i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            mode_d[i]   = mode_q[i];
            wr_hit[i]   = counter_we && (counter_ch == CHW'(i));

            // Auto-reload output is a single-cycle pulse
            if (mode_q[i] == MODE_AUTO) begin
                ch_out_d[i] = 1'b0;
            end

            if (wr_hit[i]) begin
                if (!ctrl_sel) begin
                    reload_d[i] = counter_val;
                    count_d[i]  = counter_val;
                    done_d[i]   = 1'b0;
                    ch_out_d[i] = 1'b0;
                    run_d[i]    = (mode_q[i] != MODE_OFF) && (counter_val != '0);
                end else begin
                    mode_d[i]   = counter_val[1:0];
                    irq_en_d[i] = counter_val[2];
                    if (counter_val[3]) begin
                        done_d[i] = 1'b0;
                    end
                    if (counter_val[4]) begin
                        count_d[i]  = reload_q[i];
                        ch_out_d[i] = 1'b0;
                        run_d[i]    = (counter_val[1:0] != MODE_OFF) && (reload_q[i] != '0);
                    end
                    if (counter_val[1:0] == MODE_OFF) begin
                        run_d[i] = 1'b0;
                    end
                end
            end else if (tick_evt[i] && run_q[i]) begin
                if (count_q[i] > CNT_ONE) begin
                    count_d[i] = count_q[i] - CNT_ONE;
                end else if (count_q[i] == CNT_ONE) begin
                    done_d[i] = 1'b1;
                    case (mode_q[i])
                        MODE_ONE: begin
                            count_d[i]  = '0;
                            run_d[i]    = 1'b0;
                            ch_out_d[i] = 1'b1;
                        end
                        MODE_AUTO: begin
                            count_d[i]  = reload_q[i];
                            ch_out_d[i] = 1'b1;
                        end
                        MODE_SQR: begin
                            count_d[i]  = reload_q[i];
                            ch_out_d[i] = ~ch_out[i];
                        end
                        default: begin
                            run_d[i]  = 1'b0;
                            done_d[i] = done[i];
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_q   <= '0;
            irq_en_q <= '0;
            run_q    <= '0;
            done     <= '0;
            ch_out   <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                mode_q[i]   <= MODE_OFF;
            end
        end else begin
            tick_q   <= tick_in;
            irq_en_q <= irq_en_d;
            run_q    <= run_d;
            done     <= done_d;
            ch_out   <= ch_out_d;
            irq      <= irq_d;
            for (int i = 0; i < int'(NCH); i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
                mode_q[i]   <= mode_d[i];
            end
        end
    end

    // Read mux; out-of-range channels read as zero
    always_comb begin
        counter_out = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (rd_ch == CHW'(i)) begin
                counter_out = count_q[i];
            end
        end
    end

endmodule

// File: tb/tb_counter_multi_ch.sv
// Scoreboard bench for counter_multi_ch: stimulus pushes per-cycle expected outputs from a
// behavioural model; an independent monitor pops and compares after each clock edge.
module tb_counter_multi_ch;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned CHW = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [NCH-1:0] tick_in;
    logic           counter_we;
    logic           ctrl_sel;
    logic [CHW-1:0] counter_ch;
    logic [CW-1:0]  counter_val;
    logic [CHW-1:0] rd_ch;
    logic [CW-1:0]  counter_out;
    logic [NCH-1:0] ch_out;
    logic [NCH-1:0] done;
    logic           irq;

    always #5 clk = ~clk;

    counter_multi_ch #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .tick_in     (tick_in),
        .counter_we  (counter_we),
        .ctrl_sel    (ctrl_sel),
        .counter_ch  (counter_ch),
        .counter_val (counter_val),
        .rd_ch       (rd_ch),
        .counter_out (counter_out),
        .ch_out      (ch_out),
        .done        (done),
        .irq         (irq)
    );

    typedef struct {
        int unsigned    tag;
        logic [CW-1:0]  cnt;
        logic [NCH-1:0] co;
        logic [NCH-1:0] dn;
        logic           irq;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          stim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [CW-1:0]  m_cnt [NCH];
    logic [CW-1:0]  m_rel [NCH];
    int unsigned    m_mode [NCH];
    logic [NCH-1:0] m_en, m_run, m_done, m_co, m_prev;
    logic           m_irq;

    task automatic model_step(input bit r, input bit we, input bit sel, input int unsigned ch,
                              input logic [CW-1:0] val, input logic [NCH-1:0] tk);
        bit any;
        bit evt;
        if (!r) begin
            for (int i = 0; i < int'(NCH); i++) begin
                m_cnt[i] = '0; m_rel[i] = '0; m_mode[i] = 0;
            end
            m_en = '0; m_run = '0; m_done = '0; m_co = '0; m_prev = '0; m_irq = 1'b0;
            return;
        end
        any = 1'b0;
        for (int i = 0; i < int'(NCH); i++) if (m_done[i] && m_en[i]) any = 1'b1;
        for (int i = 0; i < int'(NCH); i++) begin
            evt = tk[i] && !m_prev[i];
            if (m_mode[i] == 2) m_co[i] = 1'b0;
            if (we && ch == i) begin
                if (!sel) begin
                    m_rel[i] = val; m_cnt[i] = val; m_done[i] = 1'b0; m_co[i] = 1'b0;
                    m_run[i] = (m_mode[i] != 0) && (val != 0);
                end else begin
                    m_mode[i] = int'(val[1:0]);
                    m_en[i] = val[2];
                    if (val[3]) m_done[i] = 1'b0;
                    if (val[4]) begin
                        m_cnt[i] = m_rel[i]; m_co[i] = 1'b0;
                        m_run[i] = (val[1:0] != 0) && (m_rel[i] != 0);
                    end
                    if (val[1:0] == 0) m_run[i] = 1'b0;
                end
            end else if (evt && m_run[i]) begin
                if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
                else if (m_cnt[i] == 1) begin
                    m_done[i] = 1'b1;
                    if (m_mode[i] == 1) begin
                        m_cnt[i] = '0; m_run[i] = 1'b0; m_co[i] = 1'b1;
                    end else if (m_mode[i] == 2) begin
                        m_cnt[i] = m_rel[i]; m_co[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_rel[i]; m_co[i] = ~m_co[i];
                    end
                end
            end
        end
        m_prev = tk;
        m_irq = any;
    endtask

    task automatic drive(input bit r, input bit we, input bit sel, input int unsigned ch,
                         input logic [CW-1:0] val, input int unsigned rd, input logic [NCH-1:0] tk);
        exp_t e;
        @(negedge clk);
        rstn = r; counter_we = we; ctrl_sel = sel; counter_ch = CHW'(ch);
        counter_val = val; rd_ch = CHW'(rd); tick_in = tk;
        model_step(r, we, sel, ch, val, tk);
        e.tag = cyc + 1;
        e.cnt = (rd < NCH) ? m_cnt[rd] : '0;
        e.co  = m_co;
        e.dn  = m_done;
        e.irq = m_irq;
        sb.push_back(e);
    endtask

    task automatic idle(input int unsigned rd, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 0, '0, rd, '0);
    endtask

    task automatic wr(input bit sel, input int unsigned ch, input logic [CW-1:0] val, input int unsigned rd);
        drive(1'b1, 1'b1, sel, ch, val, rd, '0);
    endtask

    task automatic pulses(input int unsigned ch, input int n);
        logic [NCH-1:0] m;
        m = '0;
        m[ch] = 1'b1;
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 1'b0, 1'b0, 0, '0, ch, m);
            drive(1'b1, 1'b0, 1'b0, 0, '0, ch, '0);
        end
    endtask

    function automatic void cmp(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // Monitor: compares DUT outputs against the queued expectation for this cycle
    initial begin
        exp_t e;
        while (!stim_done) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                cmp("tag", CW'(e.tag), CW'(cyc));
                cmp("counter_out", counter_out, e.cnt);
                cmp("ch_out", CW'(ch_out), CW'(e.co));
                cmp("done", CW'(done), CW'(e.dn));
                cmp("irq", CW'(irq), CW'(e.irq));
            end
        end
        cmp("leftover", CW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit r, we, sel;
        int unsigned ch, rd;
        logic [CW-1:0] val;
        rstn = 1'b0; counter_we = 1'b0; ctrl_sel = 1'b0; counter_ch = '0;
        counter_val = '0; rd_ch = '0; tick_in = '0;

        // Reset held with toggling ticks and an attempted write
        for (int k = 0; k < 6; k++) drive(1'b0, k == 3, 1'b0, 0, 32'd7, 0, (k % 2 == 0) ? '1 : '0);
        idle(0, 2);

        // One-shot with irq enabled
        wr(1'b1, 0, 32'h05, 0);
        wr(1'b0, 0, 32'd3, 0);
        pulses(0, 5);
        idle(0, 2);

        // Auto-reload, then W1C done
        wr(1'b1, 1, 32'h02, 1);
        wr(1'b0, 1, 32'd4, 1);
        pulses(1, 12);
        wr(1'b1, 1, 32'h0A, 1);
        idle(1, 2);

        // Square wave
        wr(1'b1, 2, 32'h03, 2);
        wr(1'b0, 2, 32'd2, 2);
        pulses(2, 8);
        idle(2, 2);

        // Collision: load and tick edge on the same edge
        wr(1'b1, 3, 32'h02, 3);
        drive(1'b1, 1'b1, 1'b0, 3, 32'd10, 3, 4'b1000);
        idle(3, 2);
        pulses(3, 1);
        // Out-of-range write and read
        wr(1'b0, NCH, 32'd99, 3);
        idle(NCH, 2);

        // Load zero never runs
        wr(1'b0, 1, 32'd0, 1);
        pulses(1, 3);
        // Freeze with mode 00, then restart
        wr(1'b1, 0, 32'h01, 0);
        wr(1'b0, 0, 32'd5, 0);
        pulses(0, 2);
        wr(1'b1, 0, 32'h00, 0);
        pulses(0, 2);
        wr(1'b1, 0, 32'h11, 0);
        pulses(0, 2);

        // Reset mid-count with a tick edge pending
        drive(1'b1, 1'b0, 1'b0, 0, '0, 0, 4'b0001);
        drive(1'b0, 1'b0, 1'b0, 0, '0, 0, 4'b0000);
        drive(1'b1, 1'b0, 1'b0, 0, '0, 0, 4'b0001);
        idle(0, 2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 499) != 0);
            we  = ($urandom_range(0, 5) == 0);
            sel = 1'($urandom_range(0, 1));
            ch  = ($urandom_range(0, 7) != 0) ? $urandom_range(0, NCH - 1) : $urandom_range(0, (1 << CHW) - 1);
            val = sel ? CW'($urandom_range(0, 31)) : CW'($urandom_range(0, 6));
            rd  = $urandom_range(0, NCH);
            drive(r, we, sel, ch, val, rd, NCH'($urandom));
        end
        idle(0, 3);
        repeat (2) @(negedge clk);
        stim_done = 1'b1;
    end

endmodule
